// File: rtl/cv32e41p_prefetch_controller_pkg.sv
// Shared types and helpers for the instruction prefetch controller.
package cv32e41p_prefetch_controller_pkg;

  typedef enum logic {
    IDLE,
    BRANCH_WAIT
  } prefetch_state_e;

  localparam logic [31:0] FETCH_STRIDE = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cv32e41p_prefetch_controller.sv
// Issues word-aligned fetch requests gated by FIFO credit and an outstanding limit,
// tracks in-flight transactions and discards responses made stale by a branch.
module cv32e41p_prefetch_controller
  import cv32e41p_prefetch_controller_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_addr_i,
  output logic             busy_o,
  output logic             trans_valid_o,
  input  logic             trans_ready_i,
  output logic [31:0]      trans_addr_o,
  input  logic             resp_valid_i,
  input  logic [CNT_W-1:0] fifo_cnt_i,
  input  logic             fifo_empty_i,
  output logic             fifo_push_o,
  output logic             fifo_pop_o,
  output logic             fifo_flush_o,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o
);

  localparam int unsigned OUT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  prefetch_state_e state_q, state_d;
  logic [31:0]      next_addr_q;
  logic [31:0]      saved_addr_q, saved_addr_d;
  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] flush_cnt_q;
  logic [SUM_W-1:0] occupancy;
  logic [31:0]      branch_target;
  logic             credit;
  logic             at_limit;
  logic             accept;

  assign branch_target = align_word(branch_addr_i);
  assign occupancy     = SUM_W'(cnt_q) + SUM_W'(fifo_cnt_i);
  assign credit        = occupancy < SUM_W'(DEPTH);
  assign at_limit      = cnt_q == OUT_W'(OUTSTANDING);
  assign accept        = trans_valid_o & trans_ready_i;

  always_comb begin
    state_d       = state_q;
    saved_addr_d  = saved_addr_q;
    trans_valid_o = 1'b0;
    trans_addr_o  = next_addr_q;
    case (state_q)
      IDLE: begin
        trans_addr_o  = branch_i ? branch_target : next_addr_q;
        trans_valid_o = (branch_i | (req_i & credit)) & ~at_limit;
        if (branch_i & ~(trans_valid_o & trans_ready_i)) begin
          state_d      = BRANCH_WAIT;
          saved_addr_d = branch_target;
        end
      end
      BRANCH_WAIT: begin
        // A fresh branch supersedes the pending target and is presented immediately
        trans_addr_o  = branch_i ? branch_target : saved_addr_q;
        trans_valid_o = ~at_limit;
        if (trans_valid_o & trans_ready_i) begin
          state_d = IDLE;
        end else if (branch_i) begin
          saved_addr_d = branch_target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept & ~resp_valid_i) begin
      cnt_d = cnt_q + OUT_W'(1);
    end else if (~accept & resp_valid_i) begin
      cnt_d = cnt_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      next_addr_q  <= '0;
      saved_addr_q <= '0;
      cnt_q        <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      saved_addr_q <= saved_addr_d;
      cnt_q        <= cnt_d;
      if (accept) begin
        next_addr_q <= trans_addr_o + FETCH_STRIDE;
      end
      // Everything already in flight is stale; a response in the branch cycle is consumed here
      if (branch_i) begin
        flush_cnt_q <= cnt_q - OUT_W'(resp_valid_i);
      end else if (resp_valid_i && (flush_cnt_q != '0)) begin
        flush_cnt_q <= flush_cnt_q - OUT_W'(1);
      end
    end
  end

  assign fifo_flush_o  = branch_i;
  assign fifo_push_o   = resp_valid_i & ~branch_i & (flush_cnt_q == '0);
  assign fetch_valid_o = ~fifo_empty_i & ~branch_i & ((flush_cnt_q == '0) | ~fifo_empty_i);
  assign fifo_pop_o    = fetch_valid_o & fetch_ready_i;
  assign busy_o        = (cnt_q != '0) | (state_q == BRANCH_WAIT);

`ifdef CV32E41P_ASSERT_ON
  a_resp_in_flight: assert property (@(posedge clk_i) disable iff (rst_i)
    resp_valid_i |-> (cnt_q != '0));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= OUT_W'(OUTSTANDING));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_push_o |-> (fifo_cnt_i != CNT_W'(DEPTH)));
`endif

endmodule

// File: tb/tb_cv32e41p_prefetch_controller.sv
// Directed bench for the prefetch controller with hand-computed expectations.
module tb_cv32e41p_prefetch_controller;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned OUTSTANDING = 2;
  localparam int unsigned CNT_W       = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_i;
  logic             branch_i;
  logic [31:0]      branch_addr_i;
  logic             busy_o;
  logic             trans_valid_o;
  logic             trans_ready_i;
  logic [31:0]      trans_addr_o;
  logic             resp_valid_i;
  logic [CNT_W-1:0] fifo_cnt_i;
  logic             fifo_empty_i;
  logic             fifo_push_o;
  logic             fifo_pop_o;
  logic             fifo_flush_o;
  logic             fetch_ready_i;
  logic             fetch_valid_o;

  int checks = 0;
  int errors = 0;

  cv32e41p_prefetch_controller #(
    .DEPTH       (DEPTH),
    .OUTSTANDING (OUTSTANDING)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .busy_o        (busy_o),
    .trans_valid_o (trans_valid_o),
    .trans_ready_i (trans_ready_i),
    .trans_addr_o  (trans_addr_o),
    .resp_valid_i  (resp_valid_i),
    .fifo_cnt_i    (fifo_cnt_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_push_o   (fifo_push_o),
    .fifo_pop_o    (fifo_pop_o),
    .fifo_flush_o  (fifo_flush_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_valid_o (fetch_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req_i         = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = '0;
    trans_ready_i = 1'b0;
    resp_valid_i  = 1'b0;
    fifo_cnt_i    = '0;
    fifo_empty_i  = 1'b1;
    fetch_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (trans_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", trans_valid_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (trans_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", trans_addr_o); end
    checks++; if ({fifo_push_o, fifo_pop_o, fifo_flush_o} !== 3'b000) begin errors++; $display("FAIL rst_fifo: got %b want 000", {fifo_push_o, fifo_pop_o, fifo_flush_o}); end
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL rst_fetch_valid: got %b want 0", fetch_valid_o); end
    req_i = 1'b1;
    #1;
    checks++; if (trans_valid_o !== 1'b1) begin errors++; $display("FAIL rst_req_valid: got %b want 1", trans_valid_o); end
  endtask

  task automatic test_branch_seq();
    do_reset();
    branch_i = 1'b1; branch_addr_i = 32'h0000_0082; trans_ready_i = 1'b1;
    #1;
    checks++; if (trans_valid_o !== 1'b1) begin errors++; $display("FAIL br_valid: got %b want 1", trans_valid_o); end
    checks++; if (trans_addr_o !== 32'h80) begin errors++; $display("FAIL br_addr: got %h want 00000080", trans_addr_o); end
    checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", fifo_flush_o); end
    tick();
    branch_i = 1'b0; req_i = 1'b1; resp_valid_i = 1'b1; fifo_empty_i = 1'b0;
    #1;
    checks++; if (trans_addr_o !== 32'h84 || trans_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_addr0: got %h/%b want 00000084/1", trans_addr_o, trans_valid_o); end
    checks++; if (fifo_push_o !== 1'b1) begin errors++; $display("FAIL b2b_push0: got %b want 1", fifo_push_o); end
    tick();
    fifo_cnt_i = 3'd1; fetch_ready_i = 1'b1;
    #1;
    checks++; if (trans_addr_o !== 32'h88 || trans_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_addr1: got %h/%b want 00000088/1", trans_addr_o, trans_valid_o); end
    checks++; if (fetch_valid_o !== 1'b1 || fifo_pop_o !== 1'b1) begin errors++; $display("FAIL b2b_pop: got %b/%b want 1/1", fetch_valid_o, fifo_pop_o); end
    tick();
    req_i = 1'b0; trans_ready_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b1 || trans_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy %b valid %b want 1/0", busy_o, trans_valid_o); end
    tick();
    resp_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_credit();
    int resp_t[7]  = '{0, 1, 1, 1, 1, 0, 0};
    int fcnt_t[7]  = '{0, 0, 1, 2, 3, 4, 4};
    int empty_t[7] = '{1, 0, 0, 0, 0, 0, 0};
    int vexp_t[7]  = '{1, 1, 1, 1, 0, 0, 0};
    int busy_t[7]  = '{0, 1, 1, 1, 1, 0, 0};
    int accepts = 0;
    do_reset();
    req_i = 1'b1; trans_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      resp_valid_i = resp_t[i][0];
      fifo_cnt_i   = CNT_W'(fcnt_t[i]);
      fifo_empty_i = empty_t[i][0];
      #1;
      checks++; if (trans_valid_o !== vexp_t[i][0]) begin errors++; $display("FAIL credit_valid[%0d]: got %b want %b", i, trans_valid_o, vexp_t[i][0]); end
      checks++; if (busy_o !== busy_t[i][0]) begin errors++; $display("FAIL credit_busy[%0d]: got %b want %b", i, busy_o, busy_t[i][0]); end
      checks++; if (fifo_push_o !== resp_t[i][0]) begin errors++; $display("FAIL credit_push[%0d]: got %b want %b", i, fifo_push_o, resp_t[i][0]); end
      if (trans_valid_o === 1'b1 && trans_ready_i === 1'b1) accepts++;
      tick();
    end
    checks++; if (accepts != 4) begin errors++; $display("FAIL credit_accepts: got %0d want 4", accepts); end
    checks++; if (trans_addr_o !== 32'h10) begin errors++; $display("FAIL credit_next_addr: got %h want 00000010", trans_addr_o); end
  endtask

  task automatic test_flush_stale();
    do_reset();
    branch_i = 1'b1; branch_addr_i = 32'h100; trans_ready_i = 1'b1;
    tick();
    branch_i = 1'b0; req_i = 1'b1;
    #1;
    checks++; if (trans_addr_o !== 32'h104 || trans_valid_o !== 1'b1) begin errors++; $display("FAIL fl_second: got %h/%b want 00000104/1", trans_addr_o, trans_valid_o); end
    tick();
    branch_i = 1'b1; branch_addr_i = 32'h200;
    #1;
    checks++; if (trans_valid_o !== 1'b0) begin errors++; $display("FAIL fl_limit: got %b want 0", trans_valid_o); end
    checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL fl_flush: got %b want 1", fifo_flush_o); end
    tick();
    branch_i = 1'b0; req_i = 1'b0; resp_valid_i = 1'b1;
    #1;
    checks++; if (fifo_push_o !== 1'b0) begin errors++; $display("FAIL fl_drop0: got %b want 0", fifo_push_o); end
    checks++; if (trans_valid_o !== 1'b0 || trans_addr_o !== 32'h200) begin errors++; $display("FAIL fl_wait: got %b/%h want 0/00000200", trans_valid_o, trans_addr_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL fl_busy: got %b want 1", busy_o); end
    tick();
    #1;
    checks++; if (fifo_push_o !== 1'b0) begin errors++; $display("FAIL fl_drop1: got %b want 0", fifo_push_o); end
    checks++; if (trans_valid_o !== 1'b1 || trans_addr_o !== 32'h200) begin errors++; $display("FAIL fl_issue: got %b/%h want 1/00000200", trans_valid_o, trans_addr_o); end
    tick();
    fifo_empty_i = 1'b0;
    #1;
    checks++; if (fifo_push_o !== 1'b1) begin errors++; $display("FAIL fl_push: got %b want 1", fifo_push_o); end
    checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL fl_fetch_valid: got %b want 1", fetch_valid_o); end
    checks++; if (trans_addr_o !== 32'h204) begin errors++; $display("FAIL fl_next_addr: got %h want 00000204", trans_addr_o); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    branch_i = 1'b1; branch_addr_i = 32'h300;
    #1;
    checks++; if (trans_valid_o !== 1'b1 || trans_addr_o !== 32'h300) begin errors++; $display("FAIL bw_first: got %b/%h want 1/00000300", trans_valid_o, trans_addr_o); end
    tick();
    branch_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (trans_valid_o !== 1'b1 || trans_addr_o !== 32'h300 || busy_o !== 1'b1) begin errors++; $display("FAIL bw_hold[%0d]: got %b/%h/%b want 1/00000300/1", i, trans_valid_o, trans_addr_o, busy_o); end
      tick();
    end
    trans_ready_i = 1'b1;
    #1;
    checks++; if (trans_valid_o !== 1'b1 || trans_addr_o !== 32'h300) begin errors++; $display("FAIL bw_accept: got %b/%h want 1/00000300", trans_valid_o, trans_addr_o); end
    tick();
    trans_ready_i = 1'b0;
    #1;
    checks++; if (trans_valid_o !== 1'b0 || trans_addr_o !== 32'h304) begin errors++; $display("FAIL bw_idle: got %b/%h want 0/00000304", trans_valid_o, trans_addr_o); end
    // Branch arriving while a previous target is still waiting
    do_reset();
    branch_i = 1'b1; branch_addr_i = 32'h500;
    tick();
    branch_addr_i = 32'h607;
    #1;
    checks++; if (trans_addr_o !== 32'h604 || fifo_flush_o !== 1'b1) begin errors++; $display("FAIL bw_override: got %h/%b want 00000604/1", trans_addr_o, fifo_flush_o); end
    tick();
    branch_i = 1'b0;
    #1;
    checks++; if (trans_addr_o !== 32'h604 || trans_valid_o !== 1'b1) begin errors++; $display("FAIL bw_override_hold: got %h/%b want 00000604/1", trans_addr_o, trans_valid_o); end
  endtask

  task automatic test_outstanding_branch();
    do_reset();
    req_i = 1'b1; trans_ready_i = 1'b1;
    tick();
    tick();
    branch_i = 1'b1; branch_addr_i = 32'h400; resp_valid_i = 1'b1;
    #1;
    checks++; if (trans_valid_o !== 1'b0) begin errors++; $display("FAIL ob_limit: got %b want 0", trans_valid_o); end
    checks++; if (fifo_push_o !== 1'b0 || fifo_flush_o !== 1'b1) begin errors++; $display("FAIL ob_branch_resp: got push %b flush %b want 0/1", fifo_push_o, fifo_flush_o); end
    tick();
    branch_i = 1'b0; req_i = 1'b0; resp_valid_i = 1'b0;
    #1;
    checks++; if (trans_valid_o !== 1'b1 || trans_addr_o !== 32'h400) begin errors++; $display("FAIL ob_issue: got %b/%h want 1/00000400", trans_valid_o, trans_addr_o); end
    tick();
    req_i = 1'b1; resp_valid_i = 1'b1;
    #1;
    checks++; if (fifo_push_o !== 1'b0) begin errors++; $display("FAIL ob_drop: got %b want 0", fifo_push_o); end
    checks++; if (trans_valid_o !== 1'b0) begin errors++; $display("FAIL ob_full: got %b want 0", trans_valid_o); end
    tick();
    req_i = 1'b0; fifo_empty_i = 1'b0;
    #1;
    checks++; if (fifo_push_o !== 1'b1 || fetch_valid_o !== 1'b1) begin errors++; $display("FAIL ob_push: got %b/%b want 1/1", fifo_push_o, fetch_valid_o); end
    tick();
    resp_valid_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ob_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFE; trans_ready_i = 1'b1;
    #1;
    checks++; if (trans_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got %h want fffffffc", trans_addr_o); end
    tick();
    branch_i = 1'b0; req_i = 1'b1; trans_ready_i = 1'b0; resp_valid_i = 1'b1;
    #1;
    checks++; if (trans_addr_o !== 32'h0 || trans_valid_o !== 1'b1) begin errors++; $display("FAIL wrap_zero: got %h/%b want 00000000/1", trans_addr_o, trans_valid_o); end
    tick();
    resp_valid_i = 1'b0; trans_ready_i = 1'b1;
    tick();
    #1;
    checks++; if (trans_addr_o !== 32'h4 || busy_o !== 1'b1) begin errors++; $display("FAIL wrap_burst: got %h/%b want 00000004/1", trans_addr_o, busy_o); end
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; trans_ready_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
    checks++; if (trans_valid_o !== 1'b1 || trans_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_addr: got %b/%h want 1/00000000", trans_valid_o, trans_addr_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_branch_seq();
    test_credit();
    test_flush_stale();
    test_branch_wait();
    test_outstanding_branch();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
